sync_alu_fifo: RTL and testbench

SYNC_ALU_FIFO -- requirements
Module: sync_alu_fifo

---
 rtl/sync_alu_pkg.sv | 31 +++
 rtl/sync_alu_fifo_alu_unit.sv | 37 +++
 rtl/sync_alu_fifo.sv | 104 ++++++++++
 tb/tb_sync_alu_fifo.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_alu_pkg.sv
// Shared opcode enumeration and command-word field helpers for the ALU FIFO.
package sync_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_MUL = 3'b100,
      OP_SLT = 3'b101,
      OP_SGT = 3'b110,
      OP_XOR = 3'b111
   } opcode_t;

   localparam int OPC_W = 3;
   localparam int B_LSB = 1;

   // Bit offsets of each field inside the full command word.
   function automatic int cmd_width(input int opw);
      return 2 * opw + 4;
   endfunction

   function automatic int opc_lsb(input int opw);
      return 2 * opw + 1;
   endfunction

   function automatic int a_lsb(input int opw);
      return opw + 1;
   endfunction

endpackage

// File: rtl/sync_alu_fifo_alu_unit.sv
// Purely combinational unsigned ALU; every result is 2*OPW bits wide.
module alu_unit
   import sync_alu_pkg::*;
#(
   parameter int OPW = 14
) (
   input  logic [OPW-1:0]   a,
   input  logic [OPW-1:0]   b,
   input  opcode_t          op,
   output logic [2*OPW-1:0] result
);

   localparam int RW = 2 * OPW;

   logic [RW-1:0] a_x;
   logic [RW-1:0] b_x;

   assign a_x = RW'(a);
   assign b_x = RW'(b);

   // Operands are widened first so SUB wraps modulo 2^RW and MUL keeps the full product.
   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = a_x + b_x;
         OP_SUB:  result = a_x - b_x;
         OP_AND:  result = a_x & b_x;
         OP_OR:   result = a_x | b_x;
         OP_MUL:  result = a_x * b_x;
         OP_SLT:  result = RW'(a < b);
         OP_SGT:  result = RW'(a > b);
         OP_XOR:  result = a_x ^ b_x;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/sync_alu_fifo.sv
// Command FIFO whose read port executes the head command through alu_unit and
// registers the result; occupancy flags come straight from registered pointers.
module sync_alu_fifo
   import sync_alu_pkg::*;
#(
   parameter int OPW       = 14,
   parameter int DEPTH     = 8,
   parameter int AF_MARGIN = 1
) (
   input  logic                   p_clk,
   input  logic                   rst,
   input  logic [2*OPW+3:0]       data_in,
   input  logic                   w_req,
   input  logic                   r_req,
   input  logic                   clr_err,
   output logic [2*OPW-1:0]       data_out,
   output logic                   valid,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int AW      = $clog2(DEPTH);
   localparam int PW      = AW + 1;
   localparam int CW      = cmd_width(OPW);
   // Bit 0 of the command is ignored, so storage drops it and field offsets shift by one.
   localparam int SW      = CW - 1;
   localparam int OPC_OFF = opc_lsb(OPW) - 1;
   localparam int A_OFF   = a_lsb(OPW) - 1;
   localparam int B_OFF   = B_LSB - 1;

   logic [SW-1:0]    mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [SW-1:0]    head;
   logic [2*OPW-1:0] alu_result;
   logic             rd_acc;
   logic             wr_acc;
   logic             ovf_evt;
   logic             udf_evt;
   logic             unused_cmd_bit;

   assign unused_cmd_bit = data_in[0];

   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign almost_full = (count >= PW'(DEPTH - AF_MARGIN));

   // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
   assign rd_acc  = r_req && !empty;
   assign wr_acc  = w_req && (!full || rd_acc);
   assign ovf_evt = w_req && full && !rd_acc;
   assign udf_evt = r_req && empty;

   assign head = mem[rd_ptr[AW-1:0]];

   alu_unit #(
      .OPW(OPW)
   ) u_alu (
      .a      (head[A_OFF +: OPW]),
      .b      (head[B_OFF +: OPW]),
      .op     (opcode_t'(head[OPC_OFF +: OPC_W])),
      .result (alu_result)
   );

   always_ff @(posedge p_clk) begin
      if (wr_acc) begin
         mem[wr_ptr[AW-1:0]] <= data_in[CW-1:1];
      end
   end

   always_ff @(posedge p_clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         valid     <= 1'b0;
         data_out  <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr   <= rd_ptr + 1'b1;
            data_out <= alu_result;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         valid <= rd_acc;
         // A fresh error in the clear cycle keeps its flag set.
         overflow  <= (clr_err ? 1'b0 : overflow)  | ovf_evt;
         underflow <= (clr_err ? 1'b0 : underflow) | udf_evt;
      end
   end

endmodule

// File: tb/tb_sync_alu_fifo.sv
// Scoreboard bench for sync_alu_fifo at default parameters (OPW=14, DEPTH=8, AF_MARGIN=1).
module tb_sync_alu_fifo;

   localparam int OPW   = 14;
   localparam int DEPTH = 8;
   localparam int CW    = 2 * OPW + 4;

   logic              p_clk;
   logic              rst;
   logic [CW-1:0]     data_in;
   logic              w_req;
   logic              r_req;
   logic              clr_err;
   logic [2*OPW-1:0]  data_out;
   logic              valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic [3:0]        count;
   logic              overflow;
   logic              underflow;

   int                checks   = 0;
   int                failures = 0;

   logic [31:0]       exp_q[$];
   logic [31:0]       m_data;
   logic              m_valid;
   logic              m_ovf;
   logic              m_udf;
   logic [31:0]       seq_exp [8];

   sync_alu_fifo #(
      .OPW       (OPW),
      .DEPTH     (DEPTH),
      .AF_MARGIN (1)
   ) dut (
      .p_clk       (p_clk),
      .rst         (rst),
      .data_in     (data_in),
      .w_req       (w_req),
      .r_req       (r_req),
      .clr_err     (clr_err),
      .data_out    (data_out),
      .valid       (valid),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial p_clk = 1'b0;
   always #5 p_clk = ~p_clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_cmd(input int op, input int a, input int b);
      logic [2:0]  o;
      logic [13:0] av;
      logic [13:0] bv;
      o  = 3'(op);
      av = 14'(a);
      bv = 14'(b);
      return {o, av, bv, 1'b0};
   endfunction

   function automatic logic [31:0] alu_model(input logic [31:0] cmd);
      longint la;
      longint lb;
      longint r;
      la = longint'(cmd[28:15]);
      lb = longint'(cmd[14:1]);
      case (cmd[31:29])
         3'd0:    r = la + lb;
         3'd1:    r = la - lb;
         3'd2:    r = la & lb;
         3'd3:    r = la | lb;
         3'd4:    r = la * lb;
         3'd5:    r = (la < lb) ? 1 : 0;
         3'd6:    r = (la > lb) ? 1 : 0;
         default: r = la ^ lb;
      endcase
      return 32'(r & 64'h0FFF_FFFF);
   endfunction

   task automatic check_state();
      check_output("valid", 32'(valid), 32'(m_valid));
      check_output("data_out", 32'(data_out), m_data);
      check_output("count", 32'(count), 32'(exp_q.size()));
      check_output("full", 32'(full), 32'(exp_q.size() == DEPTH));
      check_output("empty", 32'(empty), 32'(exp_q.size() == 0));
      check_output("almost_full", 32'(almost_full), 32'(exp_q.size() >= DEPTH - 1));
      check_output("overflow", 32'(overflow), 32'(m_ovf));
      check_output("underflow", 32'(underflow), 32'(m_udf));
   endtask

   // One clock cycle: inputs driven at the falling edge, outputs checked at the next one.
   task automatic apply_stimulus(input logic w, input logic r, input logic c, input logic [31:0] cmd);
      logic rd_m;
      logic wr_m;
      logic ovf_new;
      logic udf_new;
      rd_m    = r && (exp_q.size() != 0);
      wr_m    = w && ((exp_q.size() < DEPTH) || rd_m);
      ovf_new = w && (exp_q.size() == DEPTH) && !rd_m;
      udf_new = r && (exp_q.size() == 0);
      w_req   = w;
      r_req   = r;
      clr_err = c;
      data_in = cmd;
      if (rd_m) m_data = exp_q.pop_front();
      if (wr_m) exp_q.push_back(alu_model(cmd));
      m_valid = rd_m;
      m_ovf   = (c ? 1'b0 : m_ovf) | ovf_new;
      m_udf   = (c ? 1'b0 : m_udf) | udf_new;
      @(posedge p_clk);
      @(negedge p_clk);
      w_req   = 1'b0;
      r_req   = 1'b0;
      clr_err = 1'b0;
      check_state();
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
   endtask

   initial begin
      seq_exp = '{32'd16, 32'd4, 32'd1, 32'd13, 32'd45, 32'd0, 32'd1, 32'd12};
      rst     = 1'b0;
      w_req   = 1'b0;
      r_req   = 1'b0;
      clr_err = 1'b0;
      data_in = '0;
      model_reset();
      repeat (3) @(negedge p_clk);
      check_state();
      rst = 1'b1;

      // Fill with the eight-opcode sequence, overflow on the ninth write, then clear.
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b0, (i == 0) ? mk_cmd(0, 8, 8) : mk_cmd(i, 9, 5));
      end
      apply_stimulus(1'b1, 1'b0, 1'b0, mk_cmd(0, 100, 100));
      apply_stimulus(1'b0, 1'b0, 1'b1, '0);
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b0, 1'b1, 1'b0, '0);
         check_output("seq_result", 32'(data_out), seq_exp[i]);
      end

      // Underflow, clear, clear-vs-new-error, and write+read on an empty FIFO.
      apply_stimulus(1'b0, 1'b1, 1'b0, '0);
      apply_stimulus(1'b0, 1'b0, 1'b1, '0);
      apply_stimulus(1'b0, 1'b1, 1'b1, '0);
      apply_stimulus(1'b0, 1'b0, 1'b1, '0);
      apply_stimulus(1'b1, 1'b1, 1'b0, mk_cmd(3, 12'h0F0, 12'h00F));
      apply_stimulus(1'b0, 1'b1, 1'b1, '0);

      // Wrap-around SUB and full-width MUL boundaries.
      apply_stimulus(1'b1, 1'b0, 1'b0, mk_cmd(1, 5, 9));
      apply_stimulus(1'b1, 1'b0, 1'b0, mk_cmd(4, 14'h3FFF, 14'h3FFF));
      apply_stimulus(1'b0, 1'b1, 1'b0, '0);
      check_output("sub_wrap", 32'(data_out), 32'h0FFF_FFFC);
      apply_stimulus(1'b0, 1'b1, 1'b0, '0);
      check_output("mul_max", 32'(data_out), 32'h0FFF_8001);

      // Full FIFO with simultaneous read and write for 20 cycles, then drain.
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b0,
                        mk_cmd($urandom_range(0, 7), $urandom_range(0, 16383), $urandom_range(0, 16383)));
      end
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'b1, 1'b1, 1'b0,
                        mk_cmd($urandom_range(0, 7), $urandom_range(0, 16383), $urandom_range(0, 16383)));
      end
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b0, 1'b1, 1'b0, '0);
      end

      // Asynchronous reset mid-stream with four entries queued and valid high.
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b0, mk_cmd(i, i + 1, 3));
      end
      apply_stimulus(1'b0, 1'b1, 1'b0, '0);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_state();
      @(negedge p_clk);
      rst = 1'b1;
      apply_stimulus(1'b0, 1'b1, 1'b0, '0);
      apply_stimulus(1'b1, 1'b0, 1'b1, mk_cmd(7, 6, 3));
      apply_stimulus(1'b0, 1'b1, 1'b0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
